decoder_scan_ctrl: RTL and testbench

Sequencer for the shared mode-selectable decoder: 2-to-4, 3-to-8 or 4-to-16, selected by `Z`, with `X` as the input and `Y` as the 16-bit one-hot output. On request it drives the decoder's `Z`/`X` inputs through every address of the selected mode, holding each for a programmable dwell. It supports single-sweep and continuous scanning, abort, and a completed-pass count. It sits between the scan-client logic (row strobes, chip selects) and the decoder instance, and owns the decoder's select inputs.

---
 rtl/decoder_scan_ctrl.sv | 84 ++++++++
 tb/tb_decoder_scan_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: sweeps a mode-selectable 2/3/4-to-N decoder through every address with a programmable dwell.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic [1:0]         Z,
    output logic [3:0]         X,
    output logic               busy,
    output logic               step_valid,
    output logic               done,
    output logic               err,
    output logic [7:0]         pass_cnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]         state;
    logic [DWELL_W-1:0] hold;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         last;
    assign busy = state == RUN;
    // Z holds the latched mode for the whole sweep, so it doubles as the mode register
    always_comb last = (Z == 2'b00) ? 4'd3 : (Z == 2'b01) ? 4'd7 : 4'd15;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            Z          <= 2'b11;
            X          <= 4'd0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pass_cnt   <= 8'd0;
            hold       <= '0;
            dwell_q    <= '0;
        end else begin
            step_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    if (mode == 2'b11) begin
                        err <= 1'b1;
                    end else begin
                        state      <= RUN;
                        Z          <= mode;
                        X          <= 4'd0;
                        step_valid <= 1'b1;
                        dwell_q    <= dwell;
                        pass_cnt   <= 8'd0;
                        hold       <= '0;
                    end
                end
            end else if (stop) begin
                state <= IDLE;
                Z     <= 2'b11;
                X     <= 4'd0;
            end else if (hold != dwell_q) begin
                hold <= hold + DWELL_W'(1);
            end else begin
                hold <= '0;
                if (X != last) begin
                    X          <= X + 4'd1;
                    step_valid <= 1'b1;
                end else begin
                    pass_cnt <= pass_cnt + 8'd1;
                    if (continuous) begin
                        X          <= 4'd0;
                        step_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Z     <= 2'b11;
                        X     <= 4'd0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: table-driven sweeps plus corner sequences, with a step scoreboard on {Z,X}.
module tb_decoder_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] dwell = 8'd0;
    logic [1:0] Z;
    logic [3:0] X;
    logic       busy, step_valid, done, err;
    logic [7:0] pass_cnt;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] dwell;
        int         n;
    } vec_t;

    vec_t       tbl[4];
    logic [5:0] exp_q[$];
    int         checks = 0;
    int         passed = 0;
    int         done_cnt = 0;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .continuous(continuous), .Z(Z), .X(X), .busy(busy),
        .step_valid(step_valid), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (busy) chk("z_valid_while_busy", int'(Z != 2'b11), 1);
            if (step_valid) begin
                chk("step_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("step_zx", int'({Z, X}), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic sweep_wait(output int cnt);
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_sweep(input logic [1:0] m, input logic [7:0] d, input int n);
        int cnt;
        @(negedge clk);
        mode = m; dwell = d; continuous = 1'b0; start = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back({m, 4'(i)});
        @(negedge clk);
        start = 1'b0;
        chk("launch_busy", int'(busy), 1);
        chk("launch_z", int'(Z), int'(m));
        chk("launch_x", int'(X), 0);
        chk("launch_step_valid", int'(step_valid), 1);
        sweep_wait(cnt);
        chk("busy_cycles", cnt, n * (int'(d) + 1));
        chk("done_after_sweep", int'(done), 1);
        chk("idle_z", int'(Z), 3);
        chk("pass_cnt_after_sweep", int'(pass_cnt), 1);
        chk("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int cnt, dc;
        tbl[0] = '{2'b00, 8'd0, 4};
        tbl[1] = '{2'b10, 8'd2, 16};
        tbl[2] = '{2'b01, 8'd1, 8};
        tbl[3] = '{2'b00, 8'd3, 4};
        #1 rst_n = 1'b0;
        #10;
        chk("rst_z", int'(Z), 3);
        chk("rst_x", int'(X), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_valid", int'(step_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_sweep(tbl[i].mode, tbl[i].dwell, tbl[i].n);

        // illegal mode
        @(negedge clk);
        mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_z", int'(Z), 3);
        @(negedge clk);
        chk("err_one_cycle", int'(err), 0);

        // start and stop together in IDLE
        mode = 2'b00; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_no_launch", int'(busy), 0);
        chk("start_stop_no_step", int'(step_valid), 0);

        // continuous scan, start/mode/dwell changes ignored, abort in 20th RUN cycle
        mode = 2'b01; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back({2'b01, 4'(i % 8)});
        dc = done_cnt;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) begin start = 1'b1; mode = 2'b10; dwell = 8'd5; end
            if (k == 7) start = 1'b0;
            if (k == 20) stop = 1'b1;
        end
        @(negedge clk);
        stop = 1'b0; continuous = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_z", int'(Z), 3);
        chk("abort_x", int'(X), 0);
        chk("abort_pass_cnt", int'(pass_cnt), 2);
        chk("abort_no_done", done_cnt - dc, 0);
        chk("abort_queue", exp_q.size(), 0);

        // start held through done relaunches the next cycle
        @(negedge clk);
        mode = 2'b00; dwell = 8'd0; start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back({2'b00, 4'(i % 4)});
        @(negedge clk);
        sweep_wait(cnt);
        chk("held_first_busy", cnt, 4);
        chk("held_first_done", int'(done), 1);
        @(negedge clk);
        start = 1'b0;
        chk("relaunch_busy", int'(busy), 1);
        chk("relaunch_x", int'(X), 0);
        chk("relaunch_step_valid", int'(step_valid), 1);
        sweep_wait(cnt);
        chk("relaunch_busy_cycles", cnt, 4);
        chk("relaunch_done", int'(done), 1);
        chk("relaunch_pass_cnt", int'(pass_cnt), 1);

        // async reset mid continuous sweep
        @(negedge clk);
        mode = 2'b00; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({2'b00, 4'(i % 4)});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_pass_cnt", int'(pass_cnt), 2);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_z", int'(Z), 3);
        chk("async_rst_x", int'(X), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_pass_cnt", int'(pass_cnt), 0);
        chk("async_rst_step_valid", int'(step_valid), 0);
        continuous = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(2'b01, 8'd0, 8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
